// File: rtl/mu0_mem_arbiter_if.sv
// rtl/mu0_mem_arbiter_if.sv - two-requester MU0 memory bus bundle
//
// Groups the two requester req/ack ports and the shared MU0 memory bus.
//   m0_* / m1_*  : req, rnw, addr, wdata from requesters; ack, rdata back
//   memrq, rnw, mem_address, mem_wdata : shared memory bus driven by arbiter
//   mem_rdata    : read data returned by memory
//   owner        : port of the most recent grant
// Modports: slave = arbiter side, master = requesters + memory side.

interface mu0_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_rnw;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_rnw;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          memrq;
    logic          rnw;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner;

    modport slave (
        input  m0_req, m0_rnw, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_rnw, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output memrq, rnw, mem_address, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output m0_req, m0_rnw, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_rnw, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  memrq, rnw, mem_address, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mu0_mem_arbiter.sv
// rtl/mu0_mem_arbiter.sv - round-robin two-port arbiter for the MU0 memory bus
//
// Shares one MU0 memory bus between two req/ack requesters. One access at a
// time: IDLE (arbitrate) -> BUSY for MEM_LAT cycles (memrq high) -> ACK
// (one-cycle ack pulse to the winner) -> IDLE.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mu0_mem_arbiter_if.slave (requester ports, memory bus, owner)
// Every output is a register; nothing from req/addr reaches the bus
// combinationally.

module mu0_mem_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mu0_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // Counter loaded at grant; the BUSY edge that sees zero is the last one.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q,      state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q,      owner_d;
    logic          rnw_lat_q,    rnw_lat_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [DW-1:0] wdata_q,      wdata_d;
    logic [3:0]    cnt_q,        cnt_d;
    logic          memrq_q,      memrq_d;
    logic          rnw_out_q,    rnw_out_d;
    logic          ack0_q,       ack0_d;
    logic          ack1_q,       ack1_d;
    logic [DW-1:0] rdata0_q,     rdata0_d;
    logic [DW-1:0] rdata1_q,     rdata1_d;

    logic          any_req;
    logic          winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;   // port 0 wins the first contention
            owner_q      <= 1'b0;
            rnw_lat_q    <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 4'd0;
            memrq_q      <= 1'b0;
            rnw_out_q    <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rnw_lat_q    <= rnw_lat_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            memrq_q      <= memrq_d;
            rnw_out_q    <= rnw_out_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rnw_lat_d    = rnw_lat_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        memrq_d      = 1'b0;
        rnw_out_d    = 1'b1;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        any_req = bus.m0_req | bus.m1_req;
        // Single requester wins outright; on contention the port that did
        // not win last time goes next.
        if (bus.m0_req && bus.m1_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.m1_req;
        end

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    last_grant_d = winner;
                    owner_d      = winner;
                    cnt_d        = CNT_INIT;
                    memrq_d      = 1'b1;
                    state_d      = S_BUSY;
                    if (winner) begin
                        rnw_lat_d = bus.m1_rnw;
                        addr_d    = bus.m1_addr;
                        wdata_d   = bus.m1_wdata;
                        rnw_out_d = bus.m1_rnw;
                    end else begin
                        rnw_lat_d = bus.m0_rnw;
                        addr_d    = bus.m0_addr;
                        wdata_d   = bus.m0_wdata;
                        rnw_out_d = bus.m0_rnw;
                    end
                end
            end

            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Final BUSY edge: the only point mem_rdata is sampled.
                    state_d = S_ACK;
                    if (rnw_lat_q) begin
                        if (owner_q) begin
                            rdata1_d = bus.mem_rdata;
                        end else begin
                            rdata0_d = bus.mem_rdata;
                        end
                    end
                    ack0_d = ~owner_q;
                    ack1_d = owner_q;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    memrq_d   = 1'b1;
                    rnw_out_d = rnw_lat_q;
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.memrq       = memrq_q;
    assign bus.rnw         = rnw_out_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.m0_ack      = ack0_q;
    assign bus.m1_ack      = ack1_q;
    assign bus.m0_rdata    = rdata0_q;
    assign bus.m1_rdata    = rdata1_q;
    assign bus.owner       = owner_q;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// tb/tb_mu0_mem_arbiter.sv - scoreboard bench for mu0_mem_arbiter (MEM_LAT 1 and 3)

module tb_mu0_mem_arbiter;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst3_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mu0_mem_arbiter_if #(.AW(12), .DW(16)) b1 ();
    mu0_mem_arbiter_if #(.AW(12), .DW(16)) b3 ();

    mu0_mem_arbiter #(.AW(12), .DW(16), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (b1)
    );

    mu0_mem_arbiter #(.AW(12), .DW(16), .MEM_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (b3)
    );

    function automatic logic [15:0] mem_fn(input logic [11:0] a);
        case (a)
            12'h005: return 16'h1234;
            12'h010: return 16'h1111;
            12'h011: return 16'h3333;
            12'h020: return 16'h2222;
            12'h021: return 16'h4444;
            12'h030: return 16'hAAAA;
            12'h031: return 16'hBBBB;
            12'h040: return 16'hCCCC;
            12'h100: return 16'h5A5A;
            12'h300: return 16'h7777;
            12'h301: return 16'h0101;
            default: return 16'hDEAD ^ {4'h0, a};
        endcase
    endfunction

    assign b1.mem_rdata = mem_fn(b1.mem_address);
    assign b3.mem_rdata = mem_fn(b3.mem_address);

    typedef struct {
        logic        port;
        logic [11:0] addr;
        logic        rnw;
        logic [15:0] wdata;
        int          len;
        logic [15:0] rd0;
        logic [15:0] rd1;
        int          gap;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int          run [2];
    int          cyc [2];
    int          last_ack [2];
    logic [11:0] a_l [2];
    logic        r_l [2];
    logic [15:0] w_l [2];
    bit          stable [2];

    task automatic check(input string what, input int d, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL lat%0d %s: actual %0h required %0h", (d == 0) ? 1 : 3, what, act, req);
        end
    endtask

    task automatic expect_acc(input int d, input logic p, input logic [11:0] a, input logic r,
                              input logic [15:0] w, input logic [15:0] rd0, input logic [15:0] rd1,
                              input int gap);
        exp_t e;
        e.port = p; e.addr = a; e.rnw = r; e.wdata = w;
        e.len = (d == 0) ? 1 : 3;
        e.rd0 = rd0; e.rd1 = rd1; e.gap = gap;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic set_port(input int d, input int p, input logic req, input logic r,
                            input logic [11:0] a, input logic [15:0] w);
        case ({d[0], p[0]})
            2'b00: begin b1.m0_req = req; b1.m0_rnw = r; b1.m0_addr = a; b1.m0_wdata = w; end
            2'b01: begin b1.m1_req = req; b1.m1_rnw = r; b1.m1_addr = a; b1.m1_wdata = w; end
            2'b10: begin b3.m0_req = req; b3.m0_rnw = r; b3.m0_addr = a; b3.m0_wdata = w; end
            default: begin b3.m1_req = req; b3.m1_rnw = r; b3.m1_addr = a; b3.m1_wdata = w; end
        endcase
    endtask

    function automatic logic get_ack(input int d, input int p);
        if (d == 0) return (p == 0) ? b1.m0_ack : b1.m1_ack;
        return (p == 0) ? b3.m0_ack : b3.m1_ack;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the ack was sampled.
    task automatic access(input int d, input int p, input logic r, input logic [11:0] a,
                          input logic [15:0] w, input bit keep);
        bit seen = 1'b0;
        set_port(d, p, 1'b1, r, a, w);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (get_ack(d, p)) seen = 1'b1;
        end
        check("ack_within_budget", d, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        if (!keep) set_port(d, p, 1'b0, r, a, w);
    endtask

    task automatic snap(input int d, output logic mq, output logic r, output logic [11:0] a,
                        output logic [15:0] w, output logic k0, output logic k1,
                        output logic [15:0] rd0, output logic [15:0] rd1, output logic own);
        if (d == 0) begin
            mq = b1.memrq; r = b1.rnw; a = b1.mem_address; w = b1.mem_wdata;
            k0 = b1.m0_ack; k1 = b1.m1_ack; rd0 = b1.m0_rdata; rd1 = b1.m1_rdata; own = b1.owner;
        end else begin
            mq = b3.memrq; r = b3.rnw; a = b3.mem_address; w = b3.mem_wdata;
            k0 = b3.m0_ack; k1 = b3.m1_ack; rd0 = b3.m0_rdata; rd1 = b3.m1_rdata; own = b3.owner;
        end
    endtask

    task automatic mon_step(input int d);
        logic        mq, r, k0, k1, own;
        logic [11:0] a;
        logic [15:0] w, rd0, rd1;
        exp_t        e;
        bit          have;
        snap(d, mq, r, a, w, k0, k1, rd0, rd1, own);
        cyc[d]++;
        if ((d == 0 && !rst1_n) || (d == 1 && !rst3_n)) begin
            run[d] = 0;
            return;
        end
        if (mq) begin
            if (run[d] == 0) begin
                a_l[d] = a; r_l[d] = r; w_l[d] = w; stable[d] = 1'b1;
            end else if (a !== a_l[d] || r !== r_l[d] || w !== w_l[d]) begin
                stable[d] = 1'b0;
            end
            run[d]++;
        end else begin
            if (k0 || k1) begin
                have = 1'b0;
                if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                check("ack_expected", d, 32'(have), 32'd1);
                check("single_ack", d, 32'(k0 & k1), 32'd0);
                if (have) begin
                    check("ack_port", d, 32'(k1), 32'(e.port));
                    check("owner", d, 32'(own), 32'(e.port));
                    check("memrq_cycles", d, 32'(run[d]), 32'(e.len));
                    check("bus_stable", d, 32'(stable[d]), 32'd1);
                    check("mem_address", d, 32'(a_l[d]), 32'(e.addr));
                    check("rnw", d, 32'(r_l[d]), 32'(e.rnw));
                    check("mem_wdata", d, 32'(w_l[d]), 32'(e.wdata));
                    check("m0_rdata", d, 32'(rd0), 32'(e.rd0));
                    check("m1_rdata", d, 32'(rd1), 32'(e.rd1));
                    if (e.gap != 0) check("ack_spacing", d, 32'(cyc[d] - last_ack[d]), 32'(e.gap));
                end
                last_ack[d] = cyc[d];
            end
            run[d] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; cyc[i] = 0; last_ack[i] = 0; stable[i] = 1'b0;
            a_l[i] = '0; r_l[i] = 1'b0; w_l[i] = '0;
        end
        forever begin
            @(negedge clk);
            mon_step(0);
            mon_step(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                set_port(d, p, 1'b0, 1'b1, 12'h000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_memrq",   0, 32'(b1.memrq), 32'd0);
        check("rst_rnw",     0, 32'(b1.rnw), 32'd1);
        check("rst_address", 0, 32'(b1.mem_address), 32'h0);
        check("rst_wdata",   0, 32'(b1.mem_wdata), 32'h0);
        check("rst_m0_ack",  0, 32'(b1.m0_ack), 32'd0);
        check("rst_m1_ack",  0, 32'(b1.m1_ack), 32'd0);
        check("rst_m0_rdata", 0, 32'(b1.m0_rdata), 32'h0);
        check("rst_m1_rdata", 0, 32'(b1.m1_rdata), 32'h0);
        check("rst_owner",   0, 32'(b1.owner), 32'd0);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk);
        #1;

        // m0 read of 0x005
        expect_acc(0, 1'b0, 12'h005, 1'b1, 16'h0000, 16'h1234, 16'h0000, 0);
        access(0, 0, 1'b1, 12'h005, 16'h0000, 1'b0);

        // m1 write of 0xBEEF to 0xFFF leaves both rdata untouched
        expect_acc(0, 1'b1, 12'hFFF, 1'b0, 16'hBEEF, 16'h1234, 16'h0000, 0);
        access(0, 1, 1'b0, 12'hFFF, 16'hBEEF, 1'b0);

        // both ports requesting continuously: m0, m1, m0, m1 at 3-cycle spacing
        expect_acc(0, 1'b0, 12'h010, 1'b1, 16'h0000, 16'h1111, 16'h0000, 0);
        expect_acc(0, 1'b1, 12'h020, 1'b1, 16'h0000, 16'h1111, 16'h2222, 3);
        expect_acc(0, 1'b0, 12'h011, 1'b1, 16'h0000, 16'h3333, 16'h2222, 3);
        expect_acc(0, 1'b1, 12'h021, 1'b1, 16'h0000, 16'h3333, 16'h4444, 3);
        fork
            begin
                access(0, 0, 1'b1, 12'h010, 16'h0000, 1'b1);
                access(0, 0, 1'b1, 12'h011, 16'h0000, 1'b0);
            end
            begin
                access(0, 1, 1'b1, 12'h020, 16'h0000, 1'b1);
                access(0, 1, 1'b1, 12'h021, 16'h0000, 1'b0);
            end
        join

        // m0 back-to-back while m1 raises req during m0's access
        expect_acc(0, 1'b0, 12'h030, 1'b1, 16'h0000, 16'hAAAA, 16'h4444, 0);
        expect_acc(0, 1'b1, 12'h040, 1'b1, 16'h0000, 16'hAAAA, 16'hCCCC, 3);
        expect_acc(0, 1'b0, 12'h031, 1'b1, 16'h0000, 16'hBBBB, 16'hCCCC, 3);
        fork
            begin
                access(0, 0, 1'b1, 12'h030, 16'h0000, 1'b1);
                access(0, 0, 1'b1, 12'h031, 16'h0000, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                access(0, 1, 1'b1, 12'h040, 16'h0000, 1'b0);
            end
        join

        // MEM_LAT=3: address held for 3 memrq cycles although m0_addr moves
        expect_acc(1, 1'b0, 12'h100, 1'b1, 16'h0000, 16'h5A5A, 16'h0000, 0);
        fork
            access(1, 0, 1'b1, 12'h100, 16'h0000, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #2;
                b3.m0_addr = 12'h200;
            end
        join

        // reset during the second BUSY cycle aborts the access
        set_port(1, 0, 1'b1, 1'b1, 12'h100, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("busy_before_reset", 1, 32'(b3.memrq), 32'd1);
        rst3_n = 1'b0;
        #1;
        check("abort_memrq",   1, 32'(b3.memrq), 32'd0);
        check("abort_m0_ack",  1, 32'(b3.m0_ack), 32'd0);
        check("abort_m0_rdata", 1, 32'(b3.m0_rdata), 32'h0);
        check("abort_rnw",     1, 32'(b3.rnw), 32'd1);
        check("abort_address", 1, 32'(b3.mem_address), 32'h0);
        check("abort_owner",   1, 32'(b3.owner), 32'd0);
        set_port(1, 0, 1'b0, 1'b1, 12'h100, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;

        // contention right after reset: port 0 has priority again
        expect_acc(1, 1'b0, 12'h301, 1'b1, 16'h0000, 16'h0101, 16'h0000, 0);
        expect_acc(1, 1'b1, 12'h300, 1'b1, 16'h0000, 16'h0101, 16'h7777, 5);
        fork
            access(1, 0, 1'b1, 12'h301, 16'h0000, 1'b0);
            access(1, 1, 1'b1, 12'h300, 16'h0000, 1'b0);
        join

        repeat (5) @(posedge clk);
        #1;
        check("lat1_queue_drained", 0, 32'(exp_q0.size()), 32'd0);
        check("lat3_queue_drained", 1, 32'(exp_q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
